// File: rtl/rw_step_counter.sv
// rw_step_counter: parametrised step counter with wrap/saturate, overflow flag and terminal halt
module rw_step_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0,
  parameter int INIT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       __in0,
  input  logic [WIDTH-1:0] __in1,
  output logic [WIDTH-1:0] __out0,
  output logic             __out1,
  output logic             __continue
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  localparam logic             SAT    = SATURATE != 0;
  typedef enum logic {RUN, HALTED} state_t;
  state_t           state;
  logic [WIDTH-1:0] st;
  logic             ovf;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] nxt_st;
  logic             nxt_ovf;
  assign inc  = __in0 == 3'b001;
  assign dec  = __in0 == 3'b010;
  assign load = __in0 == 3'b011;
  // diff[WIDTH] is the borrow, i.e. st < STEP
  always_comb begin
    sum     = {1'b0, st} + {1'b0, STEP_W};
    diff    = {1'b0, st} - {1'b0, STEP_W};
    nxt_st  = inc  ? ((sum[WIDTH] && SAT) ? '1 : sum[WIDTH-1:0]) :
              dec  ? ((diff[WIDTH] && SAT) ? '0 : diff[WIDTH-1:0]) :
              load ? __in1 : st;
    nxt_ovf = (inc && sum[WIDTH]) || (dec && diff[WIDTH]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      st    <= INIT_W;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      st    <= nxt_st;
      ovf   <= nxt_ovf;
      state <= (__in0 == 3'b100) ? HALTED : RUN;
    end else begin
      ovf <= 1'b0;
    end
  end
  assign __out0     = st;
  assign __out1     = ovf;
  assign __continue = state == RUN;
endmodule

// File: tb/tb_rw_step_counter.sv
// tb_rw_step_counter: scoreboard bench for default (wrap, step 1) and saturating step-3 instances
module tb_rw_step_counter;
  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] cmd_a, cmd_b;
  logic [7:0] val_a, val_b;
  logic [7:0] out0_a, out0_b;
  logic       out1_a, out1_b, cont_a, cont_b;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_st [2];
  logic       m_ovf [2];
  logic       m_run [2];
  logic [9:0] q [$];

  always #5 clk = ~clk;

  rw_step_counter dut_a (
    .clk(clk), .rst(rst_a), .__in0(cmd_a), .__in1(val_a),
    .__out0(out0_a), .__out1(out1_a), .__continue(cont_a)
  );

  rw_step_counter #(.WIDTH(8), .STEP(3), .SATURATE(1), .INIT(0)) dut_b (
    .clk(clk), .rst(rst_b), .__in0(cmd_b), .__in1(val_b),
    .__out0(out0_b), .__out1(out1_b), .__continue(cont_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int s, input logic [2:0] c, input logic [7:0] v, input logic r);
    int stp;
    int x;
    stp = (s == 1) ? 3 : 1;
    if (r) begin
      m_st[s] = 8'h00; m_ovf[s] = 1'b0; m_run[s] = 1'b1;
    end else if (!m_run[s]) begin
      m_ovf[s] = 1'b0;
    end else begin
      m_ovf[s] = 1'b0;
      if (c == 3'd1) begin
        x = int'(m_st[s]) + stp;
        if (x > 255) begin
          m_ovf[s] = 1'b1;
          x = (s == 1) ? 255 : x - 256;
        end
        m_st[s] = x[7:0];
      end else if (c == 3'd2) begin
        x = int'(m_st[s]) - stp;
        if (x < 0) begin
          m_ovf[s] = 1'b1;
          x = (s == 1) ? 0 : x + 256;
        end
        m_st[s] = x[7:0];
      end else if (c == 3'd3) begin
        m_st[s] = v;
      end else if (c == 3'd4) begin
        m_run[s] = 1'b0;
      end
    end
  endtask

  task automatic drive(input string tag, input int s, input logic [2:0] c, input logic [7:0] v, input logic r);
    logic [9:0] e;
    logic [9:0] got;
    @(negedge clk);
    rst_a = (s == 0) ? r : 1'b0;
    cmd_a = (s == 0) ? c : 3'd0;
    val_a = v;
    rst_b = (s == 1) ? r : 1'b0;
    cmd_b = (s == 1) ? c : 3'd0;
    val_b = v;
    model(s, c, v, r);
    model(1 - s, 3'd0, v, 1'b0);
    q.push_back({m_run[s], m_ovf[s], m_st[s]});
    @(posedge clk);
    #1;
    e = q.pop_front();
    got = (s == 0) ? {cont_a, out1_a, out0_a} : {cont_b, out1_b, out0_b};
    check({tag, "_st"}, 32'(got[7:0]), 32'(e[7:0]));
    check({tag, "_ovf"}, 32'(got[8]), 32'(e[8]));
    check({tag, "_run"}, 32'(got[9]), 32'(e[9]));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; cmd_a = 3'd0; cmd_b = 3'd0; val_a = 8'h00; val_b = 8'h00;
    m_st[0] = 8'h00; m_st[1] = 8'h00; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_run[0] = 1'b1; m_run[1] = 1'b1;
    // reset both instances for two cycles
    drive("t1_rst", 0, 3'd0, 8'h00, 1'b1);
    drive("t1_rst", 1, 3'd0, 8'h00, 1'b1);
    drive("t1_idle", 0, 3'd0, 8'h00, 1'b0);
    check("t1_out0", 32'(out0_a), 32'h00);
    check("t1_cont", 32'(cont_a), 32'd1);
    drive("t2_load", 0, 3'd3, 8'hFE, 1'b0);
    drive("t2_inc1", 0, 3'd1, 8'h00, 1'b0);
    check("t2_ff", 32'({out1_a, out0_a}), 32'h0FF);
    drive("t2_inc2", 0, 3'd1, 8'h00, 1'b0);
    check("t2_wrap", 32'({out1_a, out0_a}), 32'h100);
    drive("t2_inc3", 0, 3'd1, 8'h00, 1'b0);
    check("t2_01", 32'({out1_a, out0_a}), 32'h001);
    drive("t3_load", 0, 3'd3, 8'h00, 1'b0);
    drive("t3_dec1", 0, 3'd2, 8'h00, 1'b0);
    check("t3_under", 32'({out1_a, out0_a}), 32'h1FF);
    drive("t3_dec2", 0, 3'd2, 8'h00, 1'b0);
    check("t3_fe", 32'({out1_a, out0_a}), 32'h0FE);
    drive("t4_load", 1, 3'd3, 8'hFD, 1'b0);
    drive("t4_inc1", 1, 3'd1, 8'h00, 1'b0);
    check("t4_sat", 32'({out1_b, out0_b}), 32'h1FF);
    drive("t4_inc2", 1, 3'd1, 8'h00, 1'b0);
    check("t4_sat2", 32'({out1_b, out0_b}), 32'h1FF);
    drive("t4_load2", 1, 3'd3, 8'h02, 1'b0);
    drive("t4_dec", 1, 3'd2, 8'h00, 1'b0);
    check("t4_zero", 32'({out1_b, out0_b}), 32'h100);
    drive("t4_load3", 1, 3'd3, 8'hFC, 1'b0);
    drive("t4_exact", 1, 3'd1, 8'h00, 1'b0);
    check("t4_exact", 32'({out1_b, out0_b}), 32'h0FF);
    drive("t5_load", 0, 3'd3, 8'h10, 1'b0);
    drive("t5_halt", 0, 3'd4, 8'h00, 1'b0);
    check("t5_cont", 32'(cont_a), 32'd0);
    for (int i = 0; i < 4; i++) drive("t5_inc", 0, 3'd1, 8'h00, 1'b0);
    drive("t5_load2", 0, 3'd3, 8'h55, 1'b0);
    drive("t5_dec", 0, 3'd2, 8'h00, 1'b0);
    check("t5_frozen", 32'({cont_a, out1_a, out0_a}), 32'h010);
    drive("t6_rst", 0, 3'd1, 8'h00, 1'b1);
    check("t6_rst", 32'({cont_a, out1_a, out0_a}), 32'h200);
    drive("t6_inc", 0, 3'd1, 8'h00, 1'b0);
    check("t6_01", 32'(out0_a), 32'h01);
    for (int c = 5; c < 8; c++) drive("t6_hold", 0, 3'(c), 8'hAA, 1'b0);
    check("t6_hold", 32'({cont_a, out1_a, out0_a}), 32'h201);
    for (int i = 0; i < 400; i++) begin
      int s;
      logic [7:0] v;
      s = int'($urandom_range(1));
      v = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : (($urandom_range(1) == 1) ? 8'hFE : 8'h01);
      drive("rnd", s, 3'($urandom_range(7)), v, $urandom_range(40) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
